// File: rtl/hdr_pkg.sv
// rtl/hdr_pkg.sv - frame buffer constants and capture FSM encoding shared by the imaging pipeline
package hdr_pkg;
  localparam int NUM_BUFS     = 6;
  localparam int PIX_PER_WORD = 16;
  localparam int WORD_W       = 256;
  localparam int ADDR_W       = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE,
    ST_DRAIN_BAD
  } state_t;

  function automatic logic [2:0] next_buf(input logic [2:0] cur);
    return (cur == 3'(NUM_BUFS - 1)) ? 3'd0 : cur + 3'd1;
  endfunction
endpackage

// File: rtl/camera_frame_packer_word_fifo.sv
// rtl/camera_frame_packer_word_fifo.sv - synchronous word FIFO carrying packed data plus its address tag
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 281
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // a full FIFO still accepts a word when the head leaves in the same cycle
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/camera_frame_packer.sv
// rtl/camera_frame_packer.sv - packs camera RGB565 bytes into 256-bit words and writes them to rotating frame buffers
module camera_frame_packer import hdr_pkg::*; #(
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter logic [24:0] FRAME_STRIDE = 25'h25800,
  parameter int          ADDR_STEP    = 8,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture_en,
  input  logic         vsync,
  input  logic         href,
  input  logic         byte_valid,
  input  logic [7:0]   pixel_byte,
  input  logic         ram_busy,
  output logic [255:0] camera_data,
  output logic         camera_wr_req,
  output logic [24:0]  cam_wr_address,
  output logic         frame_done,
  output logic [2:0]   last_frame,
  output logic         frame_error
);
  localparam int TOTAL_WORDS = H_RES * V_RES / PIX_PER_WORD;
  localparam int WIDX_W      = $clog2(TOTAL_WORDS + 1);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(TOTAL_WORDS - 1);

  state_t              state_q, state_d;
  logic                vsync_q, vsync_d;
  logic                toggle_q, toggle_d;
  logic [7:0]          lo_byte_q, lo_byte_d;
  logic [3:0]          pix_cnt_q, pix_cnt_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic                bad_q, bad_d;
  logic [WORD_W-1:0]   camera_data_q, camera_data_d;
  logic                wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                frame_done_q, frame_done_d;
  logic [2:0]          last_frame_q, last_frame_d;
  logic                frame_error_q, frame_error_d;

  logic [2:0]          wr_buf;
  logic [ADDR_W-1:0]   word_addr;
  logic [WORD_W-1:0]   pack_ins;
  logic                capturing, pix_valid, word_push, overflow;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W+ADDR_W-1:0] fifo_rd;

  word_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W + ADDR_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_push),
    .push_data ({word_addr, pack_ins}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    wr_buf    = next_buf(last_frame_q);
    word_addr = ADDR_W'(wr_buf) * FRAME_STRIDE + ADDR_W'(word_idx_q) * ADDR_W'(ADDR_STEP);
    capturing = (state_q == ST_CAPTURE);
    pix_valid = capturing && href && byte_valid && toggle_q;
    pack_ins  = pack_q;
    pack_ins[{pix_cnt_q, 4'b0000} +: 16] = {pixel_byte, lo_byte_q};
    word_push = pix_valid && (pix_cnt_q == 4'hF);
    fifo_pop  = !fifo_empty && !ram_busy;
    overflow  = word_push && fifo_full && !fifo_pop;

    state_d       = state_q;
    vsync_d       = vsync;
    toggle_d      = toggle_q;
    lo_byte_d     = lo_byte_q;
    pix_cnt_d     = pix_cnt_q;
    pack_d        = pack_q;
    word_idx_d    = word_idx_q;
    bad_d         = bad_q;
    camera_data_d = camera_data_q;
    wr_req_d      = fifo_pop;
    addr_d        = addr_q;
    frame_done_d  = 1'b0;
    last_frame_d  = last_frame_q;
    frame_error_d = frame_error_q;

    // the byte pairing restarts on every line, so an odd trailing byte is simply forgotten
    if (!href) begin
      toggle_d = 1'b0;
    end else if (capturing && byte_valid) begin
      toggle_d = !toggle_q;
      if (!toggle_q) lo_byte_d = pixel_byte;
    end
    if (pix_valid) begin
      pack_d    = pack_ins;
      pix_cnt_d = pix_cnt_q + 4'd1;
    end
    if (word_push) word_idx_d = word_idx_q + WIDX_W'(1);
    if (overflow) begin
      frame_error_d = 1'b1;
      bad_d         = 1'b1;
    end
    if (fifo_pop) begin
      camera_data_d = fifo_rd[WORD_W-1:0];
      addr_d        = fifo_rd[WORD_W+ADDR_W-1:WORD_W];
    end

    case (state_q)
      ST_IDLE: begin
        if (vsync_q && !vsync && capture_en) begin
          toggle_d   = 1'b0;
          pix_cnt_d  = 4'd0;
          word_idx_d = '0;
          bad_d      = 1'b0;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (word_push && (word_idx_q == LAST_IDX)) begin
          state_d = ST_FLUSH;
        end else if (!vsync_q && vsync) begin
          frame_error_d = 1'b1;
          state_d       = ST_DRAIN_BAD;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty) begin
          if (bad_q) begin
            state_d = ST_IDLE;
          end else begin
            frame_done_d = 1'b1;
            last_frame_d = wr_buf;
            state_d      = ST_DONE;
          end
        end
      end
      ST_DONE:      state_d = ST_IDLE;
      ST_DRAIN_BAD: if (fifo_empty) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      vsync_q       <= 1'b0;
      toggle_q      <= 1'b0;
      lo_byte_q     <= 8'd0;
      pix_cnt_q     <= 4'd0;
      pack_q        <= '0;
      word_idx_q    <= '0;
      bad_q         <= 1'b0;
      camera_data_q <= '0;
      wr_req_q      <= 1'b0;
      addr_q        <= '0;
      frame_done_q  <= 1'b0;
      last_frame_q  <= 3'(NUM_BUFS - 1);
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      toggle_q      <= toggle_d;
      lo_byte_q     <= lo_byte_d;
      pix_cnt_q     <= pix_cnt_d;
      pack_q        <= pack_d;
      word_idx_q    <= word_idx_d;
      bad_q         <= bad_d;
      camera_data_q <= camera_data_d;
      wr_req_q      <= wr_req_d;
      addr_q        <= addr_d;
      frame_done_q  <= frame_done_d;
      last_frame_q  <= last_frame_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign camera_data    = camera_data_q;
  assign camera_wr_req  = wr_req_q;
  assign cam_wr_address = addr_q;
  assign frame_done     = frame_done_q;
  assign last_frame     = last_frame_q;
  assign frame_error    = frame_error_q;
endmodule

// File: tb/tb_camera_frame_packer.sv
// tb/tb_camera_frame_packer.sv - scoreboard bench for camera_frame_packer
module tb_camera_frame_packer;
  localparam int          H      = 32;
  localparam int          V      = 4;
  localparam int          DEPTH  = 4;
  localparam logic [24:0] STRIDE = 25'h25800;

  logic         clk = 1'b0;
  logic         rst, capture_en, vsync, href, byte_valid, ram_busy;
  logic [7:0]   pixel_byte;
  logic [255:0] camera_data;
  logic         camera_wr_req;
  logic [24:0]  cam_wr_address;
  logic         frame_done;
  logic [2:0]   last_frame;
  logic         frame_error;

  always #5 clk = ~clk;

  camera_frame_packer #(
    .H_RES(H), .V_RES(V), .FRAME_STRIDE(STRIDE), .ADDR_STEP(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .vsync(vsync), .href(href),
    .byte_valid(byte_valid), .pixel_byte(pixel_byte), .ram_busy(ram_busy),
    .camera_data(camera_data), .camera_wr_req(camera_wr_req), .cam_wr_address(cam_wr_address),
    .frame_done(frame_done), .last_frame(last_frame), .frame_error(frame_error)
  );

  logic [280:0] exp_wr_q[$];
  logic [2:0]   exp_done_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           lf_model = 5;
  logic         err_model = 1'b0;
  logic         busy_prev = 1'b0;
  int           since_wr = 100;
  logic [255:0] first_word = '0;
  logic         got_first = 1'b0;

  task automatic check(input string name, input logic [280:0] act, input logic [280:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input int seed, input int n);
    return 8'((n + seed * 37) & 255);
  endfunction

  function automatic logic [255:0] exp_word(input int seed, input int w);
    logic [255:0] r;
    for (int p = 0; p < 16; p++)
      r[16*p +: 16] = {fbyte(seed, 32*w + 2*p + 1), fbyte(seed, 32*w + 2*p)};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) busy_prev <= ram_busy;

  always @(negedge clk) begin
    logic [280:0] e;
    if (rst) begin
      since_wr = 100;
    end else begin
      since_wr++;
      if (camera_wr_req) begin
        since_wr = 0;
        check("wr_while_busy", 281'(busy_prev), 281'(0));
        if (!got_first) begin
          got_first  = 1'b1;
          first_word = camera_data;
        end
        if (exp_wr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0h want none", cam_wr_address);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 281'(cam_wr_address), 281'(e[280:256]));
          check("wr_data", 281'(camera_data), 281'(e[255:0]));
        end
      end
      if (frame_done) begin
        check("done_gap", 281'(since_wr), 281'(1));
        if (exp_done_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_done: got last_frame %0d want none", last_frame);
        end else begin
          check("done_last_frame", 281'(last_frame), 281'(exp_done_q.pop_front()));
        end
      end
    end
  end

  task automatic drain_and_check(input string name);
    for (int i = 0; i < 400 && (exp_wr_q.size() != 0 || exp_done_q.size() != 0); i++) step();
    n_cmp++;
    if (exp_wr_q.size() != 0 || exp_done_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d writes %0d dones pending want 0", name, exp_wr_q.size(), exp_done_q.size());
      exp_wr_q.delete();
      exp_done_q.delete();
    end
    repeat (8) step();
    check({name, "_frame_error"}, 281'(frame_error), 281'(err_model));
    check({name, "_last_frame"}, 281'(last_frame), 281'(lf_model));
  endtask

  task automatic run_frame(input string name, input int seed, input int n_lines,
                           input int odd_line, input int busy_words);
    int          wb, n;
    logic [24:0] base;
    logic        bad;
    wb   = (lf_model == 5) ? 0 : lf_model + 1;
    base = 25'(wb) * STRIDE;
    for (int w = 0; w < n_lines * 2; w++)
      if (!(w < busy_words && w >= DEPTH))
        exp_wr_q.push_back({base + 25'(8 * w), exp_word(seed, w)});
    bad = (busy_words > DEPTH) || (n_lines < V);
    if (bad) err_model = 1'b1;
    else begin
      exp_done_q.push_back(3'(wb));
      lf_model = wb;
    end
    vsync = 1'b1;
    repeat (4) step();
    vsync    = 1'b0;
    ram_busy = (busy_words > 0);
    repeat (3) step();
    n = 0;
    for (int l = 0; l < n_lines; l++) begin
      href = 1'b1;
      for (int b = 0; b < 64 + ((l == odd_line) ? 1 : 0); b++) begin
        if (b == 64) pixel_byte = 8'hAA;
        else begin
          if (n == 32 * busy_words) ram_busy = 1'b0;
          pixel_byte = fbyte(seed, n);
          n++;
        end
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        pixel_byte = 8'h55;
        step();
      end
      href = 1'b0;
      repeat (4) step();
    end
    ram_busy = 1'b0;
    vsync    = 1'b1;
    drain_and_check(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_data"}, 281'(camera_data), 281'(0));
    check({name, "_wr_req"}, 281'(camera_wr_req), 281'(0));
    check({name, "_addr"}, 281'(cam_wr_address), 281'(0));
    check({name, "_frame_done"}, 281'(frame_done), 281'(0));
    check({name, "_last_frame"}, 281'(last_frame), 281'(5));
    check({name, "_frame_error"}, 281'(frame_error), 281'(0));
  endtask

  initial begin
    rst = 1'b1; capture_en = 1'b1; vsync = 1'b1; href = 1'b0;
    byte_valid = 1'b0; pixel_byte = 8'h00; ram_busy = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    run_frame("basic", 0, V, -1, 0);
    check("word0_low_pixel", 281'(first_word[15:0]), 281'(16'h0100));
    check("word0_high_pixel", 281'(first_word[255:240]), 281'(16'h1F1E));

    for (int f = 1; f <= 6; f++) run_frame("rotate", f, V, -1, 0);
    run_frame("busy3", 7, V, -1, 3);
    run_frame("odd_byte", 8, V, 0, 0);
    run_frame("overflow", 9, V, -1, 5);

    rst = 1'b1;
    step();
    rst = 1'b0;
    lf_model = 5;
    err_model = 1'b0;
    step();
    run_frame("short", 10, 1, -1, 0);
    run_frame("after_short", 11, V, -1, 0);

    vsync = 1'b1;
    repeat (4) step();
    vsync    = 1'b0;
    ram_busy = 1'b1;
    repeat (3) step();
    href = 1'b1;
    for (int b = 0; b < 64; b++) begin
      pixel_byte = 8'(b);
      byte_valid = 1'b1;
      step();
    end
    byte_valid = 1'b0;
    href = 1'b0;
    step();
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    step();
    step();
    rst = 1'b0;
    ram_busy = 1'b0;
    lf_model = 5;
    err_model = 1'b0;
    repeat (5) step();
    check("idle_after_rst_no_write", 281'(camera_wr_req), 281'(0));
    run_frame("after_rst", 12, V, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
